seq_signed_divider: RTL and testbench

- Sequential signed divider, the inverse of the team's combinational 5-bit Booth multiplier.
- Takes a 2N-bit signed dividend (product width) and an N-bit signed divisor (multiplicand width).
- Returns a truncating quotient and remainder, using one restoring-division step per clock on magnitudes.
- Sits beside the multiplier in the arithmetic lab datapath; recovers Q from a product and M.

---
 rtl/seq_signed_divider.sv | 155 +++++++++++++++
 tb/tb_seq_signed_divider.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, one restoring step per clock.
// Optional overflow detection (-2^(2N-1) / -1) is enabled by defining SEQ_DIV_OVF_DETECT_EN.
module seq_signed_divider #(
  parameter int unsigned N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = $clog2(W2);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state_q, state_d;
  logic [W2-1:0]   a_q, a_d;
  logic [N-1:0]    d_q, d_d;
  logic [N-1:0]    r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            dz_q, dz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W2-1:0]   quotient_q, quotient_d;
  logic [N-1:0]    remainder_q, remainder_d;
  logic            div_by_zero_q, div_by_zero_d;
  logic            overflow_q, overflow_d;

  // The settled remainder is always below |divisor|, so only the trial value needs N+1 bits.
  logic [N:0]      r_shift;
  logic [N:0]      r_sub;
  logic            r_ge;

  always_comb begin
    r_shift = {r_q, a_q[W2-1]};
    r_sub   = r_shift - {1'b0, d_q};
    r_ge    = (r_shift >= {1'b0, d_q});
  end

  // Next-state and datapath control.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    d_d           = d_q;
    r_d           = r_q;
    cnt_d         = cnt_q;
    neg_q_d       = neg_q_q;
    neg_r_d       = neg_r_q;
    dz_d          = dz_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            a_d     = '0;
            d_d     = '0;
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            dz_d    = 1'b1;
            state_d = FIX;
          end else begin
            a_d     = dividend[W2-1] ? W2'(-dividend) : dividend;
            d_d     = divisor[N-1] ? N'(-divisor) : divisor;
            neg_q_d = dividend[W2-1] ^ divisor[N-1];
            neg_r_d = dividend[W2-1];
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        busy_d = 1'b1;
        r_d    = r_ge ? N'(r_sub) : N'(r_shift);
        a_d    = {a_q[W2-2:0], r_ge};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W2 - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        done_d        = 1'b1;
        quotient_d    = neg_q_q ? W2'(-a_q) : a_q;
        remainder_d   = neg_r_q ? N'(-r_q) : r_q;
        div_by_zero_d = dz_q;
`ifdef SEQ_DIV_OVF_DETECT_EN
        overflow_d    = !dz_q && !neg_q_q && (a_q == {1'b1, {(W2-1){1'b0}}});
`else
        overflow_d    = 1'b0;
`endif
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      d_q           <= '0;
      r_q           <= '0;
      cnt_q         <= '0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      d_q           <= d_d;
      r_q           <= r_d;
      cnt_q         <= cnt_d;
      neg_q_q       <= neg_q_d;
      neg_r_q       <= neg_r_d;
      dz_q          <= dz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider (N=5); honours SEQ_DIV_OVF_DETECT_EN for overflow.
module tb_seq_signed_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] dividend;
  logic [4:0] divisor;
  logic       busy, done;
  logic [9:0] quotient;
  logic [4:0] remainder;
  logic       div_by_zero, overflow;

  typedef struct packed {
    logic [9:0] q;
    logic [4:0] r;
    logic       dz;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

`ifdef SEQ_DIV_OVF_DETECT_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  seq_signed_divider #(.N(5)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic do_op(input logic [9:0] dvd, input logic [4:0] dvs,
                       input logic [9:0] eq, input logic [4:0] er,
                       input logic edz, input logic eovf,
                       input int lat, input int bcyc, input bit ign);
    exp_t e;
    int   cyc;
    int   nbusy;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.ovf = eovf;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    nbusy = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      if (ign && (cyc == 2 || cyc == 5)) begin
        start    = 1'b1;
        dividend = 10'd50;
        divisor  = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'd1, 32'd0);
    chk("latency", 32'(cyc), 32'(lat));
    chk("busy_cycles", 32'(nbusy), 32'(bcyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dt[3];
    int nd;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    do_op(10'd100,     5'd7,      10'd14,     5'd2,      1'b0, 1'b0, 11, 10, 1'b0);
    do_op(10'(-100),   5'd7,      10'(-14),   5'(-2),    1'b0, 1'b0, 11, 10, 1'b0);
    do_op(10'd77,      5'(-5),    10'(-15),   5'd2,      1'b0, 1'b0, 11, 10, 1'b0);
    do_op(10'(-77),    5'(-5),    10'd15,     5'(-2),    1'b0, 1'b0, 11, 10, 1'b0);
    do_op(10'd0,       5'(-3),    10'd0,      5'd0,      1'b0, 1'b0, 11, 10, 1'b0);
    do_op(10'(-512),   5'(-1),    10'(-512),  5'd0,      1'b0, OVF,  11, 10, 1'b0);
    do_op(10'(-512),   5'd1,      10'(-512),  5'd0,      1'b0, 1'b0, 11, 10, 1'b0);
    do_op(10'd511,     5'(-16),   10'(-31),   5'd15,     1'b0, 1'b0, 11, 10, 1'b0);
    do_op(10'(-512),   5'(-16),   10'd32,     5'd0,      1'b0, 1'b0, 11, 10, 1'b0);
    do_op(10'(-7),     5'd15,     10'd0,      5'(-7),    1'b0, 1'b0, 11, 10, 1'b0);
    do_op(10'd123,     5'd0,      10'd0,      5'd0,      1'b1, 1'b0, 1,  0,  1'b0);
    do_op(10'd511,     5'd1,      10'd511,    5'd0,      1'b0, 1'b0, 11, 10, 1'b0);
    // Start pulses while busy must be dropped.
    do_op(10'd100,     5'd7,      10'd14,     5'd2,      1'b0, 1'b0, 11, 10, 1'b1);

    // Start held high: accepts at edges 0, 12, 24.
    @(negedge clk);
    dividend = 10'd100; divisor = 5'd7; start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(exp_t'{10'd14, 5'd2, 1'b0, 1'b0});
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done && nd < 3) begin
        dt[nd] = c;
        nd++;
      end
      if (c == 25) start = 1'b0;
    end
    chk("b2b_count", 32'(nd), 32'd3);
    chk("b2b_first", 32'(dt[0]), 32'd11);
    chk("b2b_gap1", 32'(dt[1] - dt[0]), 32'd12);
    chk("b2b_gap2", 32'(dt[2] - dt[1]), 32'd12);

    // Reset during the fifth CALC cycle aborts without a done.
    @(negedge clk);
    dividend = 10'(-100); divisor = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    repeat (15) @(negedge clk);
    do_op(10'd100,     5'd7,      10'd14,     5'd2,      1'b0, 1'b0, 11, 10, 1'b0);

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
